psc_tx_frame_arbiter: RTL and testbench



---
 rtl/psc_tx_frame_arbiter.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_psc_tx_frame_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/psc_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// psc_tx_frame_arbiter
//
// Shares the single PSC serial TX link between three frame sources (trigger,
// setpoint write, status poll). Incoming request pulses are latched as pending
// flags. In IDLE one source is granted, and its frame of FRAME_BYTES bytes is
// then sequenced to the UART through a valid/ready handshake. A programmable
// idle gap follows each frame.
//
// Optional build macro:
//   PSC_TX_ROUND_ROBIN_EN - setpoint and poll alternate using a one-bit
//                           last-served register. Trigger keeps absolute
//                           priority. When undefined, the fixed priority is
//                           trigger > setpoint > poll.
//
// Parameters:
//   FRAME_BYTES  bytes per frame (2..15)
//   GAP_CYCLES   idle clocks between frames (0..255, 0 = no gap)
//
// Ports:
//   clk           system clock
//   reset         synchronous active-low reset
//   req_trigger   trigger frame request pulse (highest priority)
//   req_setpoint  setpoint frame request pulse
//   req_poll      status poll frame request pulse
//   tx_ready      UART can accept a byte
//   tx_valid      byte at byte_index is offered to the UART
//   byte_index    current byte within the frame
//   frame_sel     granted source: 0 trigger, 1 setpoint, 2 poll
//   busy          high in GRANT, SEND and GAP
//   frame_done    one-cycle pulse after the last byte is accepted
//   pending       {poll, setpoint, trigger} pending flags
//   overrun_cnt   saturating count of requests lost to a set flag
// -----------------------------------------------------------------------------
module psc_tx_frame_arbiter #(
  parameter int unsigned FRAME_BYTES = 10,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_trigger,
  input  logic       req_setpoint,
  input  logic       req_poll,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [3:0] byte_index,
  output logic [1:0] frame_sel,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] pending,
  output logic [7:0] overrun_cnt
);

  localparam logic [3:0] LAST_BYTE    = 4'(FRAME_BYTES - 32'd1);
  localparam logic [7:0] GAP_LAST     = (GAP_CYCLES > 32'd0) ? 8'(GAP_CYCLES - 32'd1) : 8'd0;
  localparam bit         HAS_GAP      = (GAP_CYCLES != 32'd0);
  localparam logic [1:0] SEL_TRIGGER  = 2'd0;
  localparam logic [1:0] SEL_SETPOINT = 2'd1;
  localparam logic [1:0] SEL_POLL     = 2'd2;

  // A 3-bit encoding leaves spare codes so that a corrupted state register
  // has a defined path back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_SEND  = 3'd2,
    ST_GAP   = 3'd3
  } state_t;

  state_t     state_r, state_s;

  logic [2:0] req_vec_s;
  logic [2:0] pending_r, pending_s;
  logic [2:0] clear_s;
  logic [2:0] overrun_s;
  logic [7:0] overrun_cnt_r, overrun_cnt_s;

  logic [2:0] grant_oh_s;
  logic [1:0] grant_sel_s;
  logic       grant_take_s;
  logic       prefer_poll_s;

  logic       tx_valid_r, tx_valid_s;
  logic [3:0] byte_index_r, byte_index_s;
  logic [1:0] frame_sel_r, frame_sel_s;
  logic       busy_r, busy_s;
  logic       frame_done_r, frame_done_s;
  logic [7:0] gap_cnt_r, gap_cnt_s;
  logic       accept_s;

  assign req_vec_s = {req_poll, req_setpoint, req_trigger};
  assign accept_s  = tx_valid_r & tx_ready;

`ifdef PSC_TX_ROUND_ROBIN_EN
  // High when poll was the last of setpoint/poll to be served. The reset
  // value makes setpoint the first preference.
  logic last_poll_r;

  // Track the last served of setpoint/poll. Only their grants flip it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_poll_r <= 1'b1;
    end else if (grant_take_s && grant_oh_s[1]) begin
      last_poll_r <= 1'b0;
    end else if (grant_take_s && grant_oh_s[2]) begin
      last_poll_r <= 1'b1;
    end else begin
      last_poll_r <= last_poll_r;
    end
  end

  assign prefer_poll_s = ~last_poll_r;
`else
  assign prefer_poll_s = 1'b0;
`endif

  // Arbitration among pending flags. Trigger always wins. The tie between
  // setpoint and poll is resolved by prefer_poll_s.
  always_comb begin
    grant_oh_s  = 3'b000;
    grant_sel_s = SEL_TRIGGER;
    if (pending_r[0]) begin
      grant_oh_s  = 3'b001;
      grant_sel_s = SEL_TRIGGER;
    end else if (pending_r[1] && pending_r[2]) begin
      if (prefer_poll_s) begin
        grant_oh_s  = 3'b100;
        grant_sel_s = SEL_POLL;
      end else begin
        grant_oh_s  = 3'b010;
        grant_sel_s = SEL_SETPOINT;
      end
    end else if (pending_r[1]) begin
      grant_oh_s  = 3'b010;
      grant_sel_s = SEL_SETPOINT;
    end else if (pending_r[2]) begin
      grant_oh_s  = 3'b100;
      grant_sel_s = SEL_POLL;
    end else begin
      grant_oh_s  = 3'b000;
      grant_sel_s = SEL_TRIGGER;
    end
  end

  // A grant is only taken from IDLE, so it can never pre-empt a frame.
  assign grant_take_s = (state_r == ST_IDLE) && (|pending_r);

  // Pending flag and overrun bookkeeping. A request on the same edge that
  // clears its own flag re-arms the flag and is not an overrun.
  always_comb begin
    clear_s       = 3'b000;
    pending_s     = pending_r;
    overrun_s     = 3'b000;
    overrun_cnt_s = overrun_cnt_r;
    if (grant_take_s) begin
      clear_s = grant_oh_s;
    end else begin
      clear_s = 3'b000;
    end
    pending_s = (pending_r & ~clear_s) | req_vec_s;
    overrun_s = req_vec_s & pending_r & ~clear_s;
    // Several simultaneous overruns count as a single increment.
    if ((|overrun_s) && (overrun_cnt_r != 8'hFF)) begin
      overrun_cnt_s = overrun_cnt_r + 8'd1;
    end else begin
      overrun_cnt_s = overrun_cnt_r;
    end
  end

  // Register the pending flags and the overrun counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_r     <= 3'b000;
      overrun_cnt_r <= 8'd0;
    end else begin
      pending_r     <= pending_s;
      overrun_cnt_r <= overrun_cnt_s;
    end
  end

  // Register the FSM state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Compute the next state and the next value of every registered output.
  always_comb begin
    state_s      = state_r;
    tx_valid_s   = tx_valid_r;
    byte_index_s = byte_index_r;
    frame_sel_s  = frame_sel_r;
    frame_done_s = 1'b0;
    gap_cnt_s    = gap_cnt_r;
    busy_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_valid_s   = 1'b0;
        byte_index_s = 4'd0;
        gap_cnt_s    = 8'd0;
        if (grant_take_s) begin
          state_s     = ST_GRANT;
          frame_sel_s = grant_sel_s;
        end else begin
          state_s     = ST_IDLE;
          frame_sel_s = frame_sel_r;
        end
      end
      ST_GRANT: begin
        // tx_valid is raised here so that it is registered high on the
        // first SEND cycle.
        byte_index_s = 4'd0;
        tx_valid_s   = 1'b1;
        state_s      = ST_SEND;
      end
      ST_SEND: begin
        if (accept_s) begin
          if (byte_index_r == LAST_BYTE) begin
            byte_index_s = 4'd0;
            tx_valid_s   = 1'b0;
            frame_done_s = 1'b1;
            gap_cnt_s    = 8'd0;
            if (HAS_GAP) begin
              state_s = ST_GAP;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            byte_index_s = byte_index_r + 4'd1;
            tx_valid_s   = 1'b1;
            state_s      = ST_SEND;
          end
        end else begin
          // The UART stalls: offer the same byte again.
          byte_index_s = byte_index_r;
          tx_valid_s   = 1'b1;
          state_s      = ST_SEND;
        end
      end
      ST_GAP: begin
        tx_valid_s = 1'b0;
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_s = 8'd0;
          state_s   = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 8'd1;
          state_s   = ST_GAP;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        tx_valid_s   = 1'b0;
        byte_index_s = 4'd0;
        frame_sel_s  = SEL_TRIGGER;
        gap_cnt_s    = 8'd0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Register the outputs and the gap counter. Reset abandons any frame in
  // flight without issuing frame_done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_valid_r   <= 1'b0;
      byte_index_r <= 4'd0;
      frame_sel_r  <= SEL_TRIGGER;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      gap_cnt_r    <= 8'd0;
    end else begin
      tx_valid_r   <= tx_valid_s;
      byte_index_r <= byte_index_s;
      frame_sel_r  <= frame_sel_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      gap_cnt_r    <= gap_cnt_s;
    end
  end

  assign tx_valid    = tx_valid_r;
  assign byte_index  = byte_index_r;
  assign frame_sel   = frame_sel_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign pending     = pending_r;
  assign overrun_cnt = overrun_cnt_r;

endmodule

// File: tb/tb_psc_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_psc_tx_frame_arbiter
//
// Directed bench for psc_tx_frame_arbiter using FRAME_BYTES=10 and
// GAP_CYCLES=4. Inputs are driven on the falling edge. Outputs are sampled on
// the falling edge, after the rising edge under test.
// -----------------------------------------------------------------------------
module tb_psc_tx_frame_arbiter;

  localparam int FB  = 10;
  localparam int GAP = 4;

`ifdef PSC_TX_ROUND_ROBIN_EN
  localparam logic [1:0] ALT_SEL = 2'd2;
`else
  localparam logic [1:0] ALT_SEL = 2'd1;
`endif

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic       req_trigger  = 1'b0;
  logic       req_setpoint = 1'b0;
  logic       req_poll     = 1'b0;
  logic       tx_ready     = 1'b1;
  logic       tx_valid;
  logic [3:0] byte_index;
  logic [1:0] frame_sel;
  logic       busy;
  logic       frame_done;
  logic [2:0] pending;
  logic [7:0] overrun_cnt;

  int total_cnt = 0;
  int bad_cnt   = 0;

  psc_tx_frame_arbiter #(
    .FRAME_BYTES(FB),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_trigger (req_trigger),
    .req_setpoint(req_setpoint),
    .req_poll    (req_poll),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .byte_index  (byte_index),
    .frame_sel   (frame_sel),
    .busy        (busy),
    .frame_done  (frame_done),
    .pending     (pending),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for a frame to start, then walk its bytes. bp selects a 1-0-0-1
  // tx_ready pattern. Returns just after the last accept edge.
  task automatic serve_frame(input string tag, input logic [1:0] exp_sel,
                             input logic [2:0] exp_pend, input bit bp);
    int idx;
    int cyc;
    int wcnt;
    idx  = 0;
    cyc  = 0;
    wcnt = 0;
    tx_ready = 1'b1;
    while ((tx_valid !== 1'b1) && (wcnt < 50)) begin
      tick();
      wcnt++;
    end
    check_val({tag, " valid"}, 32'(tx_valid), 32'd1);
    check_val({tag, " pend"}, 32'(pending), 32'(exp_pend));
    while ((idx < FB) && (cyc < 200)) begin
      tx_ready = bp ? (((cyc % 4) == 0) || ((cyc % 4) == 3)) : 1'b1;
      check_val({tag, " byte"}, {23'd0, busy, frame_sel, tx_valid, frame_done, byte_index},
                {23'd0, 1'b1, exp_sel, 1'b1, 1'b0, idx[3:0]});
      if (tx_ready) idx++;
      tick();
      cyc++;
    end
    check_val({tag, " accepts"}, idx, FB);
    check_val({tag, " done"}, {26'd0, frame_done, tx_valid, byte_index}, {26'd0, 1'b1, 1'b0, 4'd0});
    tx_ready = 1'b1;
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) tick();
    check_val("reset outs", {14'd0, tx_valid, byte_index, frame_sel, busy, frame_done, pending, overrun_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // Single trigger: latency, byte walk, frame_done and gap length
    req_trigger = 1'b1;
    tick();
    req_trigger = 1'b0;
    check_val("t1 e0", {busy, tx_valid, pending}, {1'b0, 1'b0, 3'b001});
    tick();
    check_val("t1 grant", {busy, tx_valid, frame_sel, pending, byte_index}, {1'b1, 1'b0, 2'd0, 3'b000, 4'd0});
    tick();
    for (int i = 0; i < FB; i++) begin
      check_val("t1 byte", {tx_valid, frame_done, frame_sel, byte_index}, {1'b1, 1'b0, 2'd0, 4'(i)});
      tick();
    end
    check_val("t1 done", {frame_done, tx_valid, busy, byte_index}, {1'b1, 1'b0, 1'b1, 4'd0});
    tick();
    check_val("t1 done pulse", frame_done, 32'd0);
    check_val("t1 gap busy", busy, 32'd1);
    tick();
    tick();
    check_val("t1 gap busy end", busy, 32'd1);
    tick();
    check_val("t1 idle", busy, 32'd0);

    // Simultaneous requests: trigger, then setpoint, then poll
    req_trigger  = 1'b1;
    req_setpoint = 1'b1;
    req_poll     = 1'b1;
    tick();
    req_trigger  = 1'b0;
    req_setpoint = 1'b0;
    req_poll     = 1'b0;
    check_val("sim pend", pending, 32'd7);
    serve_frame("sim trig", 2'd0, 3'b110, 1'b0);
    serve_frame("sim sp", 2'd1, 3'b100, 1'b0);
    serve_frame("sim poll", 2'd2, 3'b000, 1'b0);

    // Backpressure 1-0-0-1
    req_setpoint = 1'b1;
    tick();
    req_setpoint = 1'b0;
    serve_frame("bp", 2'd1, 3'b000, 1'b1);

    // Overrun while a setpoint frame stalls in SEND
    tx_ready     = 1'b0;
    req_setpoint = 1'b1;
    tick();
    req_setpoint = 1'b0;
    n = 0;
    while ((tx_valid !== 1'b1) && (n < 50)) begin
      tick();
      n++;
    end
    for (int k = 1; k <= 300; k++) begin
      req_poll = 1'b1;
      tick();
      if (k == 100) check_val("ovr mid", overrun_cnt, 32'd99);
    end
    req_poll = 1'b0;
    check_val("ovr sat", overrun_cnt, 32'd255);
    check_val("ovr stall", {tx_valid, frame_sel, byte_index, pending}, {1'b1, 2'd1, 4'd0, 3'b100});
    serve_frame("ovr sp", 2'd1, 3'b100, 1'b0);
    serve_frame("ovr poll", 2'd2, 3'b000, 1'b0);
    repeat (10) tick();
    check_val("ovr one poll", {busy, tx_valid, pending}, 32'd0);

    // Reset in the middle of a frame
    req_setpoint = 1'b1;
    tick();
    req_setpoint = 1'b0;
    n = 0;
    while ((tx_valid !== 1'b1) && (n < 50)) begin
      tick();
      n++;
    end
    req_poll = 1'b1;
    tick();
    req_poll = 1'b0;
    n = 0;
    while ((byte_index !== 4'd5) && (n < 20)) begin
      tick();
      n++;
    end
    check_val("rst at 5", {byte_index, pending}, {4'd5, 3'b100});
    reset = 1'b0;
    tick();
    check_val("rst outs", {14'd0, tx_valid, byte_index, frame_sel, busy, frame_done, pending, overrun_cnt}, 32'd0);
    reset = 1'b1;
    tick();
    check_val("rst no done", {frame_done, busy}, 32'd0);
    req_trigger = 1'b1;
    tick();
    req_trigger = 1'b0;
    serve_frame("rst restart", 2'd0, 3'b000, 1'b0);

    // Setpoint and poll held continuously
    req_setpoint = 1'b1;
    req_poll     = 1'b1;
    serve_frame("cont f1", 2'd1, 3'b110, 1'b0);
    serve_frame("cont f2", ALT_SEL, 3'b110, 1'b0);
    serve_frame("cont f3", 2'd1, 3'b110, 1'b0);
    serve_frame("cont f4", ALT_SEL, 3'b110, 1'b0);
    req_setpoint = 1'b0;
    req_poll     = 1'b0;
    serve_frame("drain sp", 2'd1, 3'b100, 1'b0);
    serve_frame("drain poll", 2'd2, 3'b000, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
